// File: rtl/clkmeas.sv
`timescale 1ns/1ps
// clkmeas: measures period and high time of a slow asynchronous square wave in clk_in cycles.
// Stall detection is compiled in when CLKMEAS_TIMEOUT_EN is defined.
module clkmeas #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 1000000
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             sig_in,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] high_time,
  output logic             meas_valid,
  input  logic             meas_ready,
  output logic             overrun,
  input  logic             clr_ovr,
  output logic             stalled
);
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_HIGH = 2'd1, S_LOW = 2'd2} state_t;
  localparam logic [WIDTH-1:0] LP_MAX = '1;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic [WIDTH-1:0]       r_cnt, r_high_cap, r_period, r_high;
  logic                   r_valid, r_ovr;
  state_t                 r_state, w_state_next;
  logic                   w_synced, w_rise, w_fall, w_edge, w_timeout;
  logic                   w_publish, w_cap_high, w_xfer, w_load, w_drop;
  logic [WIDTH-1:0]       w_cap, w_period;
  logic [WIDTH:0]         w_sum;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], sig_in};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign w_synced = r_sync[SYNC_STAGES-1];
  assign w_rise   = w_synced & ~r_prev;
  assign w_fall   = ~w_synced & r_prev;
  assign w_edge   = w_rise | w_fall;
  assign w_cap    = (r_cnt == LP_MAX) ? LP_MAX : r_cnt + 1'b1;

  // The counter restarts on every edge, so a period is the sum of its high and low phases.
  assign w_sum    = {1'b0, r_high_cap} + {1'b0, w_cap};
  assign w_period = w_sum[WIDTH] ? LP_MAX : w_sum[WIDTH-1:0];

  always_ff @(posedge clk_in) begin
    if (rst)                  r_cnt <= '0;
    else if (w_edge)          r_cnt <= '0;
    else if (r_cnt != LP_MAX) r_cnt <= r_cnt + 1'b1;
  end

`ifdef CLKMEAS_TIMEOUT_EN
  localparam logic [WIDTH-1:0] LP_TO_LAST = WIDTH'(TIMEOUT - 1);
  logic r_stalled;

  // An edge in the same cycle proves the input is alive, so it outranks the timeout.
  assign w_timeout = (r_state != S_IDLE) && !w_edge && (r_cnt == LP_TO_LAST);

  always_ff @(posedge clk_in) begin
    if (rst)            r_stalled <= 1'b0;
    else if (w_timeout) r_stalled <= 1'b1;
    else if (w_rise)    r_stalled <= 1'b0;
  end
  assign stalled = r_stalled;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT != 0);
  assign w_timeout        = 1'b0;
  assign stalled          = 1'b0;
`endif

  always_ff @(posedge clk_in) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_rise) w_state_next = S_HIGH;
      S_HIGH:  if (w_fall) w_state_next = S_LOW;
      S_LOW:   if (w_rise) w_state_next = S_HIGH;
      default: w_state_next = S_IDLE;
    endcase
    if (w_timeout) w_state_next = S_IDLE;
  end

  always_comb begin
    w_publish  = 1'b0;
    w_cap_high = 1'b0;
    case (r_state)
      S_HIGH:  w_cap_high = w_fall;
      S_LOW:   w_publish  = w_rise;
      default: ;
    endcase
  end

  assign w_xfer = r_valid & meas_ready;
  assign w_load = w_publish & (~r_valid | w_xfer);
  assign w_drop = w_publish & r_valid & ~meas_ready;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_high_cap <= '0;
      r_period   <= '0;
      r_high     <= '0;
      r_valid    <= 1'b0;
      r_ovr      <= 1'b0;
    end else begin
      if (w_cap_high) r_high_cap <= w_cap;
      if (w_load) begin
        r_period <= w_period;
        r_high   <= r_high_cap;
        r_valid  <= 1'b1;
      end else if (w_xfer) begin
        r_valid  <= 1'b0;
      end
      r_ovr <= w_drop | (r_ovr & ~clr_ovr);
    end
  end

  assign period     = r_period;
  assign high_time  = r_high;
  assign meas_valid = r_valid;
  assign overrun    = r_ovr;
endmodule

// File: tb/tb_clkmeas.sv
`timescale 1ns/1ps
// Self-checking bench for clkmeas: three instances (32-bit, 8-bit saturating, 16-bit short timeout)
// share the stimulus; expected results come from the phase lengths the bench itself drives.
module tb_clkmeas;
`ifdef CLKMEAS_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b1, sig = 1'b0, ready = 1'b1, clr = 1'b0;
  logic [31:0] p32, h32;
  logic [7:0]  p8, h8;
  logic [15:0] pt, ht;
  logic v32, o32, s32, v8, o8, s8, vt, ot, st;

  always #5 clk = ~clk;

  clkmeas #(.WIDTH(32), .SYNC_STAGES(2)) dut32 (
    .clk_in(clk), .rst(rst), .sig_in(sig), .period(p32), .high_time(h32), .meas_valid(v32),
    .meas_ready(ready), .overrun(o32), .clr_ovr(clr), .stalled(s32));
  clkmeas #(.WIDTH(8), .SYNC_STAGES(2), .TIMEOUT(1000)) dut8 (
    .clk_in(clk), .rst(rst), .sig_in(sig), .period(p8), .high_time(h8), .meas_valid(v8),
    .meas_ready(ready), .overrun(o8), .clr_ovr(clr), .stalled(s8));
  clkmeas #(.WIDTH(16), .SYNC_STAGES(3), .TIMEOUT(50)) dut_to (
    .clk_in(clk), .rst(rst), .sig_in(sig), .period(pt), .high_time(ht), .meas_valid(vt),
    .meas_ready(ready), .overrun(ot), .clr_ovr(clr), .stalled(st));

  int n_checks = 0, n_pass = 0;
  int cyc = 0;
  int h_arr[$], l_arr[$];
  longint exp_p[$], exp_h[$];
  longint got_p[$], got_h[$];
  int got_c[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic longint sat(input longint v, input int w);
    longint m;
    m = (longint'(1) << w) - 1;
    return (v > m) ? m : v;
  endfunction

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; sig = 1'b0; ready = 1'b1; clr = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Low for a few cycles, then one rise followed by each (high, low) pair, ending on a held rise.
  task automatic drive_pattern();
    repeat (3) @(posedge clk);
    #1 sig = 1'b1;
    for (int i = 0; i < h_arr.size(); i++) begin
      repeat (h_arr[i]) @(posedge clk);
      #1 sig = 1'b0;
      repeat (l_arr[i]) @(posedge clk);
      #1 sig = 1'b1;
    end
  endtask

  task automatic build_expect(input int w);
    exp_p.delete(); exp_h.delete();
    for (int i = 0; i < h_arr.size(); i++) begin
      exp_p.push_back(sat(longint'(h_arr[i] + l_arr[i]), w));
      exp_h.push_back(sat(longint'(h_arr[i]), w));
    end
  endtask

  task automatic capture(input int sel, input int n, input int budget);
    got_p.delete(); got_h.delete(); got_c.delete();
    for (int c = 0; c < budget && got_p.size() < n; c++) begin
      @(negedge clk);
      if (sel == 0 && v32 && ready) begin got_p.push_back(p32); got_h.push_back(h32); got_c.push_back(cyc); end
      if (sel == 1 && v8  && ready) begin got_p.push_back(p8);  got_h.push_back(h8);  got_c.push_back(cyc); end
      if (sel == 2 && vt  && ready) begin got_p.push_back(pt);  got_h.push_back(ht);  got_c.push_back(cyc); end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++; if ({p32, h32} !== 64'd0) $display("FAIL reset_data got %0d/%0d want 0/0", p32, h32); else n_pass++;
    n_checks++; if (v32 !== 1'b0) $display("FAIL reset_valid got %b want 0", v32); else n_pass++;
    n_checks++; if (o32 !== 1'b0) $display("FAIL reset_overrun got %b want 0", o32); else n_pass++;
    n_checks++; if (s32 !== 1'b0 || st !== 1'b0) $display("FAIL reset_stalled got %b%b want 00", s32, st); else n_pass++;
    n_checks++; if ({p8, h8, v8, o8} !== 18'd0) $display("FAIL reset_w8 got %h want 0", {p8, h8, v8, o8}); else n_pass++;
    #1 rst = 1'b0;
  endtask

  task automatic test_divider();
    do_reset();
    h_arr.delete(); l_arr.delete();
    for (int i = 0; i < 12; i++) begin h_arr.push_back(2); l_arr.push_back(2); end
    build_expect(32);
    fork
      drive_pattern();
      capture(0, 12, 80);
    join
    n_checks++; if (got_p.size() !== 12) $display("FAIL div_count got %0d want 12", got_p.size()); else n_pass++;
    for (int i = 0; i < got_p.size(); i++) begin
      $display("div   #%0d period=%0d high=%0d cyc=%0d", i, got_p[i], got_h[i], got_c[i]);
      n_checks++; if (got_p[i] !== exp_p[i] || got_h[i] !== exp_h[i])
        $display("FAIL div_result #%0d got %0d/%0d want %0d/%0d", i, got_p[i], got_h[i], exp_p[i], exp_h[i]); else n_pass++;
      if (i > 0) begin
        n_checks++; if (got_c[i] - got_c[i-1] !== 4)
          $display("FAIL div_spacing #%0d got %0d want 4", i, got_c[i] - got_c[i-1]); else n_pass++;
      end
    end
    @(negedge clk);
    n_checks++; if (o32 !== 1'b0) $display("FAIL div_overrun got %b want 0", o32); else n_pass++;
  endtask

  task automatic test_random();
    do_reset();
    h_arr.delete(); l_arr.delete();
    for (int i = 0; i < 10; i++) begin
      h_arr.push_back(int'($urandom_range(1, 20)));
      l_arr.push_back(int'($urandom_range(1, 20)));
    end
    build_expect(32);
    fork
      drive_pattern();
      capture(0, 10, 500);
    join
    n_checks++; if (got_p.size() !== 10) $display("FAIL rnd_count got %0d want 10", got_p.size()); else n_pass++;
    for (int i = 0; i < got_p.size(); i++) begin
      $display("rnd   #%0d period=%0d high=%0d", i, got_p[i], got_h[i]);
      n_checks++; if (got_p[i] !== exp_p[i] || got_h[i] !== exp_h[i])
        $display("FAIL rnd_result #%0d got %0d/%0d want %0d/%0d", i, got_p[i], got_h[i], exp_p[i], exp_h[i]); else n_pass++;
    end
  endtask

  task automatic drive_async(input int n);
    int j_prev, j_new;
    @(posedge clk); #8;
    j_prev = int'($urandom_range(0, 4));
    #(j_prev) sig = 1'b1;
    for (int k = 0; k < n; k++) begin
      j_new = int'($urandom_range(0, 4));
      #(300 - j_prev + j_new) sig = 1'b0;
      j_prev = j_new;
      j_new = int'($urandom_range(0, 4));
      #(700 - j_prev + j_new) sig = 1'b1;
      j_prev = j_new;
    end
  endtask

  task automatic test_async();
    do_reset();
    fork
      drive_async(6);
      capture(0, 6, 800);
    join
    n_checks++; if (got_p.size() !== 6) $display("FAIL async_count got %0d want 6", got_p.size()); else n_pass++;
    for (int i = 0; i < got_p.size(); i++) begin
      $display("async #%0d period=%0d high=%0d", i, got_p[i], got_h[i]);
      n_checks++; if (got_p[i] < 99 || got_p[i] > 101 || got_h[i] < 29 || got_h[i] > 31)
        $display("FAIL async_result #%0d got %0d/%0d want 100+-1/30+-1", i, got_p[i], got_h[i]); else n_pass++;
    end
  endtask

  task automatic test_overrun();
    do_reset();
    ready = 1'b0;
    h_arr = '{5, 7, 6};
    l_arr = '{5, 3, 6};
    drive_pattern();
    repeat (8) @(negedge clk);
    $display("ovr   held period=%0d high=%0d valid=%b overrun=%b", p32, h32, v32, o32);
    n_checks++; if (v32 !== 1'b1 || p32 !== 32'd10 || h32 !== 32'd5)
      $display("FAIL ovr_hold got v=%b %0d/%0d want v=1 10/5", v32, p32, h32); else n_pass++;
    n_checks++; if (o32 !== 1'b1) $display("FAIL ovr_set got %b want 1", o32); else n_pass++;
    @(posedge clk); #1 clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0;
    @(negedge clk);
    n_checks++; if (o32 !== 1'b0 || v32 !== 1'b1) $display("FAIL ovr_clear got ovr=%b v=%b want 0/1", o32, v32); else n_pass++;
    @(posedge clk); #1 ready = 1'b1;
    @(posedge clk); #1 ready = 1'b0;
    @(negedge clk);
    n_checks++; if (v32 !== 1'b0 || o32 !== 1'b0) $display("FAIL ovr_xfer got v=%b ovr=%b want 0/0", v32, o32); else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    ready = 1'b0;
    h_arr = '{8, 8};
    l_arr = '{4, 4};
    drive_pattern();
    repeat (6) @(posedge clk);
    #1 rst = 1'b1; sig = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    $display("rstm  after reset period=%0d high=%0d valid=%b overrun=%b", p32, h32, v32, o32);
    n_checks++; if ({p32, h32, v32, o32, s32} !== 67'd0)
      $display("FAIL rstmid_clear got %0d/%0d v=%b o=%b s=%b want all 0", p32, h32, v32, o32, s32); else n_pass++;
    ready = 1'b1;
    h_arr = '{9};
    l_arr = '{6};
    build_expect(32);
    fork
      drive_pattern();
      capture(0, 1, 60);
    join
    n_checks++; if (got_p.size() !== 1 || got_p[0] !== exp_p[0] || got_h[0] !== exp_h[0])
      $display("FAIL rstmid_first got n=%0d %0d/%0d want 1 %0d/%0d", got_p.size(),
               got_p.size() > 0 ? got_p[0] : 0, got_h.size() > 0 ? got_h[0] : 0, exp_p[0], exp_h[0]); else n_pass++;
    capture(0, 1, 12);
    n_checks++; if (got_p.size() !== 0) $display("FAIL rstmid_extra got %0d results want 0", got_p.size()); else n_pass++;
  endtask

  task automatic test_saturate();
    do_reset();
    h_arr = '{100, 280, 50};
    l_arr = '{200, 20, 60};
    build_expect(8);
    fork
      drive_pattern();
      capture(1, 3, 800);
    join
    n_checks++; if (got_p.size() !== 3) $display("FAIL sat_count got %0d want 3", got_p.size()); else n_pass++;
    for (int i = 0; i < got_p.size(); i++) begin
      $display("sat   #%0d period=%0d high=%0d", i, got_p[i], got_h[i]);
      n_checks++; if (got_p[i] !== exp_p[i] || got_h[i] !== exp_h[i])
        $display("FAIL sat_result #%0d got %0d/%0d want %0d/%0d", i, got_p[i], got_h[i], exp_p[i], exp_h[i]); else n_pass++;
    end
  endtask

  task automatic test_timeout();
    bit seen_valid;
    do_reset();
    seen_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 sig = 1'b1;
    repeat (40) begin @(negedge clk); if (vt) seen_valid = 1'b1; end
    n_checks++; if (st !== 1'b0) $display("FAIL to_early got %b want 0", st); else n_pass++;
    repeat (30) begin @(negedge clk); if (vt) seen_valid = 1'b1; end
    $display("to    after hold stalled=%b valid_seen=%b", st, seen_valid);
    n_checks++; if (st !== TO_EN) $display("FAIL to_stalled got %b want %b", st, TO_EN); else n_pass++;
    n_checks++; if (seen_valid !== 1'b0) $display("FAIL to_novalid got %b want 0", seen_valid); else n_pass++;
    @(posedge clk); #1 sig = 1'b0;
    // Without stall detection the 70-cycle hold is a genuine high phase and is measured.
    exp_p.delete(); exp_h.delete();
    if (!TO_EN) begin exp_p.push_back(75); exp_h.push_back(70); end
    exp_p.push_back(20); exp_h.push_back(10);
    repeat (2) @(posedge clk);
    #1;
    h_arr = '{10};
    l_arr = '{10};
    fork
      drive_pattern();
      capture(2, exp_p.size(), 120);
    join
    n_checks++; if (got_p.size() !== exp_p.size()) $display("FAIL to_count got %0d want %0d", got_p.size(), exp_p.size()); else n_pass++;
    for (int i = 0; i < got_p.size() && i < exp_p.size(); i++) begin
      $display("to    #%0d period=%0d high=%0d", i, got_p[i], got_h[i]);
      n_checks++; if (got_p[i] !== exp_p[i] || got_h[i] !== exp_h[i])
        $display("FAIL to_result #%0d got %0d/%0d want %0d/%0d", i, got_p[i], got_h[i], exp_p[i], exp_h[i]); else n_pass++;
    end
    @(negedge clk);
    n_checks++; if (st !== 1'b0) $display("FAIL to_resume got %b want 0", st); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_divider();
    test_random();
    test_async();
    test_overrun();
    test_reset_mid();
    test_saturate();
    test_timeout();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
